imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-loader controller that fills the instruction memory of the single-cycle LEGv8 processor from a byte stream (UART/debug bridge).
- Holds the CPU in reset while loading, assembles little-endian 32-bit words and issues one write per word to the instruction RAM's write port.
- Releases the CPU when the image is complete and valid.
- Sits between the host byte link, the instruction memory write port and the CPU reset input.

Parameters:
- N, 32, instruction word width in bits (fixed 4 bytes per word; N must be 32).
- AW, 6, word-address width (64-word instruction memory).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a load session; sampled only in IDLE, DONE or ERR
- rx_valid  input  1  byte on rx_data is valid
- rx_data  input  8  stream byte
- rx_ready  output  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
- wr_en  output  1  instruction memory write strobe, one cycle per word
- wr_addr  output  AW  word address of write
- wr_data  output  N  assembled instruction word
- cpu_reset  output  1  hold processor in reset
- busy  output  1  load session in progress
- done  output  1  image loaded, CPU released
- err  output  1  session aborted on bad length or checksum

Behaviour:
- Async reset: state IDLE. rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, busy=0, done=0, err=0, byte/word counters=0, checksum=0x00.
- All outputs are registered.
- States: IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
- IDLE / DONE / ERR + start=1:
  - go to LEN; clear counters, checksum, done, err.
  - cpu_reset=1, busy=1.
- LEN:
  - rx_ready=1; one byte = word count C.
  - C==0 or C>2^AW -> ERR. Otherwise store C and go to DATA.
- DATA:
  - rx_ready=1; each accepted byte goes into byte lane k (k=0 first, bits 7:0; k=3 bits 31:24) and is XORed into the checksum.
  - On the 4th byte go to WRITE.
- WRITE (1 cycle):
  - rx_ready=0, wr_en=1, wr_addr=word index, wr_data=assembled word. Index increments afterwards.
  - If index==C-1 -> CHK (macro on) or DONE (macro off); else -> DATA.
- Latency: 4th byte accepted at edge t -> wr_en high in cycle t+1 -> next byte can be accepted at edge t+2.
- Throughput: 4 bytes per 5 cycles max. rx_valid low simply stalls any receive state; no timeout.
- DONE:
  - cpu_reset=0, done=1, busy=0, rx_ready=0.
  - wr_addr/wr_data hold the last write; wr_en=0.
- ERR:
  - cpu_reset=1, err=1, busy=0, rx_ready=0. The partially written image remains in memory.
- Bytes presented while rx_ready=0 are not consumed (no transfer).
- start while busy is ignored; start held high in DONE/ERR restarts immediately (1-cycle pass through nothing, next state LEN).
- Reset mid-session: immediate return to reset values; no further writes. Memory contents are not cleared.
- Address wrap impossible: C is bounded to 2^AW; wr_addr never exceeds C-1.

Optional Feature:
- Macro IMEM_LOADER_CHKSUM_EN.
- Defined:
  - after the last WRITE, state CHK (rx_ready=1) takes one byte.
  - Byte == XOR of all data bytes -> DONE; mismatch -> ERR.
- Undefined:
  - no CHK state; last WRITE goes straight to DONE.
  - No checksum byte is consumed; err is only raised for a bad length.

Test Plan:
- Reset then start with stream 01, 01 00 00 F8 (plus checksum F9 if enabled):
  - one write wr_addr=0, wr_data=0xF8000001.
  - Then done=1, cpu_reset=0, busy=0.
- Length byte 00 -> err=1, cpu_reset=1, no wr_en; length 0x41 -> same ERR response.
- C=3, words F8000001, F8008002, 8B050083 with rx_valid toggling every other cycle:
  - exactly 3 wr_en pulses at addresses 0,1,2 with those words.
  - rx_ready low in each WRITE cycle.
- Macro on, C=1, bytes 01 00 00 F8, checksum 00 (wrong, expected F9):
  - word written, then err=1, done=0, cpu_reset=1.
  - start then a correct stream -> done=1.
- Assert reset after 2 of 4 data bytes:
  - all outputs return to reset values within the same cycle (asynchronous); no wr_en.
  - A later start with C=1 loads correctly to address 0.
- start pulsed during DATA: ignored. After DONE, start -> cpu_reset=1, busy=1, done=0 on the next cycle.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot loader that fills the LEGv8 instruction RAM from a byte
// stream and holds the CPU in reset until a complete, valid image is loaded.
// Latency: the 4th byte of a word is accepted at edge t, wr_en is high in cycle
// t+1, and the next byte can be accepted at edge t+2.
// Backpressure: rx_ready is low outside LEN/DATA/CHK. rx_valid low stalls any
// receive state indefinitely.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             begin a session (sampled in IDLE/DONE/ERR only)
//   rx_valid/rx_data  host byte stream; rx_ready is the accept handshake
//   wr_en/wr_addr/wr_data  instruction RAM write port, one strobe per word
//   cpu_reset         holds the processor in reset (low only in DONE)
//   busy/done/err     session status
//
// Build option: define IMEM_LOADER_CHKSUM_EN to require a trailing checksum
// byte. This byte is the XOR of all data bytes and is checked after the last write.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  // Largest legal word count is the full memory depth.
  localparam logic [8:0]  MAX_C = 9'(1 << AW);
  localparam logic [AW:0] ONE_C = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;     // word count C from the length byte
  logic [AW-1:0] idx_q, idx_d;     // index of the word being assembled
  logic [1:0]    bcnt_q, bcnt_d;   // byte lane within the current word
  logic [23:0]   asm_q, asm_d;     // lanes 0..2; lane 3 arrives with the write
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]    chk_q, chk_d;
`endif

  logic          rx_ready_q, rx_ready_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0]  wr_data_q, wr_data_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic xfer;
  logic last_word;

  // rx_ready is registered from the next state, so it always reflects the
  // current state and the handshake is a plain AND.
  assign xfer      = rx_valid & rx_ready_q;
  assign last_word = ({1'b0, idx_q} == (cnt_q - ONE_C));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          cnt_d   = '0;
          idx_d   = '0;
          bcnt_d  = '0;
          asm_d   = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
          chk_d   = 8'h00;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          if ((rx_data == 8'h00) || ({1'b0, rx_data} > MAX_C)) begin
            state_d = S_ERR;
          end else begin
            cnt_d   = rx_data[AW:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          chk_d  = chk_q ^ rx_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            default: begin
              // The 4th byte completes the word; launch the write directly.
              wr_data_d = {rx_data, asm_q};
              wr_addr_d = idx_q;
              state_d   = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHKSUM_EN
        if (xfer) begin
          state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
        end
`else
        state_d = S_ERR;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every output is a flop.
  always_comb begin
    rx_ready_d  = 1'b0;
    wr_en_d     = 1'b0;
    cpu_reset_d = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_d)
      S_LEN, S_DATA, S_CHK: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        wr_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      S_ERR: err_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      asm_q       <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk_q       <= 8'h00;
`endif
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      asm_q       <= asm_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
      rx_ready_q  <= rx_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Expected writes are queued by the stimulus, and a
// negedge monitor pops and compares them whenever wr_en is seen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.N(32), .AW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Status vector order: rx_ready, wr_en, cpu_reset, busy, done, err
  localparam logic [5:0] ST_RESET = 6'b001000;
  localparam logic [5:0] ST_BUSY  = 6'b101100;
  localparam logic [5:0] ST_DONE  = 6'b000010;
  localparam logic [5:0] ST_ERR   = 6'b001001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_stat(input string name, input logic [5:0] exp);
    check(name, {26'b0, rx_ready, wr_en, cpu_reset, busy, done, err}, {26'b0, exp});
  endtask

  // Monitor: every write must match the head of the scoreboard, and
  // the loader must not accept bytes during a write cycle.
  always @(negedge clk) begin
    if (reset === 1'b0 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %h, none expected", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {26'b0, wr_addr}, {26'b0, mon_e.addr});
        check("wr_data", wr_data, mon_e.data);
      end
      check("rx_ready_in_write", {31'b0, rx_ready}, 32'd0);
    end
  end

  // All tasks start and end at a negedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check("rx_accept_timeout", 32'd1, 32'd0);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0], gap);
      v = v >> 8;
    end
  endtask

  task automatic send_chk(input logic [7:0] c);
`ifdef IMEM_LOADER_CHKSUM_EN
    send_byte(c, 1'b0);
`else
    if (c == 8'hxx) @(negedge clk);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done === 1'b1 || err === 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("session_end_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_stat("reset_status", ST_RESET);
    check("reset_wr_addr", {26'b0, wr_addr}, 32'd0);
    check("reset_wr_data", wr_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_stat("idle_status", ST_RESET);

    // Single-word image
    pulse_start();
    check_stat("start_status", ST_BUSY);
    exp_q.push_back('{6'd0, 32'hF8000001});
    send_byte(8'h01, 1'b0);
    send_word(32'hF8000001, 1'b0);
    send_chk(8'hF9);
    wait_end();
    check_stat("one_word_done", ST_DONE);
    check("done_hold_addr", {26'b0, wr_addr}, 32'd0);
    check("done_hold_data", wr_data, 32'hF8000001);

    // Bad lengths: zero and one past the memory depth
    pulse_start();
    send_byte(8'h00, 1'b0);
    wait_end();
    check_stat("len_zero_err", ST_ERR);
    pulse_start();
    send_byte(8'h41, 1'b0);
    wait_end();
    check_stat("len_65_err", ST_ERR);

    // Three words with rx_valid toggling every other cycle
    pulse_start();
    exp_q.push_back('{6'd0, 32'hF8000001});
    exp_q.push_back('{6'd1, 32'hF8008002});
    exp_q.push_back('{6'd2, 32'h8B050083});
    send_byte(8'h03, 1'b1);
    send_word(32'hF8000001, 1'b1);
    send_word(32'hF8008002, 1'b1);
    send_word(32'h8B050083, 1'b1);
    send_chk(8'h8E);
    wait_end();
    check_stat("three_word_done", ST_DONE);
    check("three_word_last_addr", {26'b0, wr_addr}, 32'd2);
    check("three_word_last_data", wr_data, 32'h8B050083);
    check("three_word_all_written", exp_q.size(), 32'd0);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Wrong checksum: word is written, then the session fails
    pulse_start();
    exp_q.push_back('{6'd0, 32'hF8000001});
    send_byte(8'h01, 1'b0);
    send_word(32'hF8000001, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end();
    check_stat("bad_chk_err", ST_ERR);
    pulse_start();
    exp_q.push_back('{6'd0, 32'hF8000001});
    send_byte(8'h01, 1'b0);
    send_word(32'hF8000001, 1'b0);
    send_byte(8'hF9, 1'b0);
    wait_end();
    check_stat("good_chk_after_err", ST_DONE);
`endif

    // Reset after two of four data bytes
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset = 1'b1;
    #1;
    check_stat("mid_reset_status", ST_RESET);
    check("mid_reset_wr_data", wr_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_stat("after_mid_reset", ST_RESET);
    pulse_start();
    exp_q.push_back('{6'd0, 32'h12345678});
    send_byte(8'h01, 1'b0);
    send_word(32'h12345678, 1'b0);
    send_chk(8'h08);
    wait_end();
    check_stat("reload_done", ST_DONE);

    // start during DATA is ignored; start after DONE restarts
    pulse_start();
    exp_q.push_back('{6'd0, 32'h8B1F03E0});
    send_byte(8'h01, 1'b0);
    send_byte(8'hE0, 1'b0);
    pulse_start();
    check_stat("start_in_data_ignored", ST_BUSY);
    send_byte(8'h03, 1'b0);
    send_byte(8'h1F, 1'b0);
    send_byte(8'h8B, 1'b0);
    send_chk(8'h77);
    wait_end();
    check_stat("ignore_start_done", ST_DONE);
    pulse_start();
    check_stat("restart_from_done", ST_BUSY);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
